// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_e;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter used for hazard performance statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// RAW interlock, branch flush and HLT drain sequencing for the 5-stage core.
// Define FORWARD_EN to enable EX operand forwarding (load-use stall only).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 4,
    parameter int HALT_DRAIN = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              branch_taken,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int DW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;

    halt_state_e   state_q;
    halt_state_e   state_d;
    logic [DW-1:0] drain_q;
    logic [DW-1:0] drain_d;
    logic          halted_q;
    logic          halted_d;

    logic ex_hit;
    logic raw;
    logic stall_inc;
    logic flush_inc;

    assign ex_hit = ex_regwrite && (ex_rd != '0) &&
                    ((id_rs_used && (id_rs == ex_rd)) ||
                     (id_rt_used && (id_rt == ex_rd)));

`ifdef FORWARD_EN
    // Only a load in EX cannot be forwarded in time.
    assign raw = ex_hit && ex_memread;
`else
    logic mem_hit;
    logic wb_hit;
    logic unused_memread;

    assign unused_memread = ex_memread;

    assign mem_hit = mem_regwrite && (mem_rd != '0) &&
                     ((id_rs_used && (id_rs == mem_rd)) ||
                      (id_rt_used && (id_rt == mem_rd)));

    assign wb_hit = wb_regwrite && (wb_rd != '0) &&
                    ((id_rs_used && (id_rs == wb_rd)) ||
                     (id_rt_used && (id_rt == wb_rd)));

    // Regfile lacks write-through, so WB writers must also interlock.
    assign raw = ex_hit || mem_hit || wb_hit;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                if (id_halt && !raw && !branch_taken) begin
                    state_d = DRAIN;
                    drain_d = DW'(HALT_DRAIN - 1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        halted_d = (state_d == HALTED);
    end

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_inc   = 1'b1;
                end else if (raw) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end
            end
            DRAIN, HALTED: begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end
            default: begin
                pc_hold = 1'b0;
            end
        endcase
    end

    assign halted = halted_q;

`ifdef FORWARD_EN
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q;
    logic [REG_AW-1:0] ex_rt_d;

    // Bubbled slots carry reg 0, which never matches a writer.
    always_comb begin
        ex_rs_d = idex_bubble ? '0 : id_rs;
        ex_rt_d = idex_bubble ? '0 : id_rt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            ex_rs_q <= ex_rs_d;
            ex_rt_q <= ex_rt_d;
        end
    end

    always_comb begin
        fwd_a = FWD_REG;
        if (mem_regwrite && (mem_rd != '0) && (ex_rs_q == mem_rd)) begin
            fwd_a = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (ex_rs_q == wb_rd)) begin
            fwd_a = FWD_WB;
        end
    end

    always_comb begin
        fwd_b = FWD_REG;
        if (mem_regwrite && (mem_rd != '0) && (ex_rt_q == mem_rd)) begin
            fwd_b = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (ex_rt_q == wb_rd)) begin
            fwd_b = FWD_WB;
        end
    end
`else
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle reference model plus directed literal checks.
module tb_hazard_ctrl;

    localparam int HALT_DRAIN = 4;
    localparam int CMAX = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       id_rs_used, id_rt_used, id_halt;
    logic       ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
    logic       branch_taken;
    logic       pc_hold, ifid_hold, idex_bubble, ifid_flush, halted;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    hazard_ctrl #(
        .REG_AW     (4),
        .HALT_DRAIN (HALT_DRAIN),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_halt      (id_halt),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .branch_taken (branch_taken),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: drain expressed as cycles remaining before halt.
    bit         m_valid = 1'b0;
    bit         m_halted;
    int         m_drain;
    int         m_stall;
    int         m_flush;
    bit         p_valid;
    logic [3:0] p_rs, p_rt;

    function automatic bit reads(input logic we, input logic [3:0] rd);
        return we && (rd != 4'd0) &&
               ((id_rs_used && id_rs == rd) || (id_rt_used && id_rt == rd));
    endfunction

    function automatic int fsel(input logic [3:0] r);
        if (!p_valid) return 0;
        if (mem_regwrite && mem_rd != 4'd0 && mem_rd == r) return 1;
        if (wb_regwrite && wb_rd != 4'd0 && wb_rd == r) return 2;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit raw, run, e_hold, e_bub, e_flush;
        int ea, eb;
`ifdef FORWARD_EN
        raw = reads(ex_regwrite, ex_rd) && ex_memread;
        ea = fsel(p_rs);
        eb = fsel(p_rt);
`else
        raw = reads(ex_regwrite, ex_rd) || reads(mem_regwrite, mem_rd) ||
              reads(wb_regwrite, wb_rd);
        ea = 0;
        eb = 0;
`endif
        run = !m_halted && m_drain == 0;
        e_hold = !run || (!branch_taken && raw);
        e_bub = !run || branch_taken || raw;
        e_flush = run && branch_taken;
        if (m_valid) begin
            chk("m_pc_hold", 32'(pc_hold), 32'(e_hold));
            chk("m_ifid_hold", 32'(ifid_hold), 32'(e_hold));
            chk("m_idex_bubble", 32'(idex_bubble), 32'(e_bub));
            chk("m_ifid_flush", 32'(ifid_flush), 32'(e_flush));
            chk("m_halted", 32'(halted), 32'(m_halted));
            chk("m_stall_cnt", 32'(stall_cnt), m_stall);
            chk("m_flush_cnt", 32'(flush_cnt), m_flush);
            chk("m_fwd_a", 32'(fwd_a), ea);
            chk("m_fwd_b", 32'(fwd_b), eb);
        end
        if (!rst_n) begin
            m_valid = 1'b1;
            m_halted = 1'b0;
            m_drain = 0;
            m_stall = 0;
            m_flush = 0;
            p_valid = 1'b0;
        end else if (m_valid) begin
            if (run && branch_taken) begin
                if (m_flush < CMAX) m_flush++;
            end else if (run && raw) begin
                if (m_stall < CMAX) m_stall++;
            end
            if (run && id_halt && !raw && !branch_taken) begin
                m_drain = HALT_DRAIN;
            end else if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) m_halted = 1'b1;
            end
            p_valid = !e_bub;
            p_rs = id_rs;
            p_rt = id_rt;
        end
    end

    task automatic idle();
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; id_halt = 0;
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
        branch_taken = 0;
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic load_use(input logic [3:0] r);
        ex_regwrite = 1; ex_memread = 1; ex_rd = r;
        id_rs = r; id_rs_used = 1;
    endtask

    int stall_base;

    initial begin
        rst_n = 0;
        idle();
        nx();
        nx();
        at_neg();
        chk("rst_pc_hold", 32'(pc_hold), 0);
        chk("rst_bubble", 32'(idex_bubble), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        nx();
        rst_n = 1;

        ex_regwrite = 1; ex_memread = 1; ex_rd = 0;
        mem_regwrite = 1; mem_rd = 0;
        id_rs = 0; id_rs_used = 1; id_rt = 0; id_rt_used = 1;
        at_neg();
        chk("r0_no_stall", 32'(idex_bubble), 0);
        chk("r0_no_hold", 32'(pc_hold), 0);
        nx();

`ifdef FORWARD_EN
        idle(); load_use(4'd3);
        at_neg();
        chk("lu_bubble", 32'(idex_bubble), 1);
        chk("lu_hold", 32'(pc_hold), 1);
        nx();
        idle(); mem_regwrite = 1; mem_rd = 3; id_rs = 3; id_rs_used = 1;
        at_neg();
        chk("lu_release", 32'(idex_bubble), 0);
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        chk("lu_bubbled_fwd", 32'(fwd_a), 0);
        nx();
        idle(); wb_regwrite = 1; wb_rd = 3;
        at_neg();
        chk("lu_fwd_wb", 32'(fwd_a), 2);
        nx();
        idle(); id_rs = 5; id_rt = 5; id_rs_used = 1; id_rt_used = 1;
        at_neg();
        nx();
        idle(); mem_regwrite = 1; mem_rd = 5;
        id_rs = 5; id_rt = 6; id_rs_used = 1; id_rt_used = 1;
        at_neg();
        chk("fwd_a_mem", 32'(fwd_a), 1);
        chk("fwd_b_mem", 32'(fwd_b), 1);
        nx();
        idle(); mem_regwrite = 1; mem_rd = 5; wb_regwrite = 1; wb_rd = 5;
        at_neg();
        chk("fwd_mem_wins", 32'(fwd_a), 1);
        chk("fwd_b_none", 32'(fwd_b), 0);
        nx();
        stall_base = 1;
`else
        idle(); ex_regwrite = 1; ex_rd = 2; id_rs = 2; id_rs_used = 1;
        at_neg();
        chk("raw_ex", 32'(idex_bubble), 1);
        nx();
        idle(); mem_regwrite = 1; mem_rd = 2; id_rs = 2; id_rs_used = 1;
        at_neg();
        chk("raw_mem", 32'(idex_bubble), 1);
        nx();
        idle(); wb_regwrite = 1; wb_rd = 2; id_rs = 2; id_rs_used = 1;
        at_neg();
        chk("raw_wb", 32'(pc_hold), 1);
        nx();
        idle(); id_rs = 2; id_rs_used = 1;
        at_neg();
        chk("raw_release", 32'(idex_bubble), 0);
        chk("raw_stall_cnt", 32'(stall_cnt), 3);
        chk("nofwd_fwd_a", 32'(fwd_a), 0);
        nx();
        idle(); wb_regwrite = 1; wb_rd = 9; id_rt = 9; id_rt_used = 1;
        at_neg();
        chk("raw_rt", 32'(idex_bubble), 1);
        nx();
        idle(); wb_regwrite = 1; wb_rd = 9; id_rt = 9; id_rt_used = 0;
        at_neg();
        chk("rt_unused", 32'(idex_bubble), 0);
        nx();
        stall_base = 4;
`endif

        idle(); load_use(4'd4); branch_taken = 1;
        at_neg();
        chk("br_flush", 32'(ifid_flush), 1);
        chk("br_pc_hold", 32'(pc_hold), 0);
        chk("br_ifid_hold", 32'(ifid_hold), 0);
        chk("br_bubble", 32'(idex_bubble), 1);
        nx();
        idle();
        at_neg();
        chk("br_flush_cnt", 32'(flush_cnt), 1);
        chk("br_stall_same", 32'(stall_cnt), stall_base);
        nx();

        idle(); id_halt = 1; branch_taken = 1;
        at_neg();
        nx();
        idle();
        at_neg();
        chk("hlt_flushed", 32'(pc_hold), 0);
        chk("hlt_flush_cnt", 32'(flush_cnt), 2);
        nx();

        idle(); id_halt = 1; load_use(4'd6);
        at_neg();
        chk("hlt_raw_hold", 32'(pc_hold), 1);
        nx();
        idle();
        at_neg();
        chk("hlt_raw_run", 32'(pc_hold), 0);
        nx();
        stall_base = stall_base + 1;

        idle(); id_halt = 1;
        at_neg();
        nx();
        idle();
        for (int k = 1; k <= 6; k++) begin
            at_neg();
            if (k == 1) chk("drain_hold", 32'(pc_hold), 1);
            if (k == 4) chk("drain_not_halted", 32'(halted), 0);
            if (k == 5) chk("halted_at_5", 32'(halted), 1);
            if (k == 6) begin
                chk("halted_hold", 32'(ifid_hold), 1);
                chk("halted_no_stall", 32'(stall_cnt), stall_base);
            end
            nx();
            if (k == 2) load_use(4'd6);
        end

        rst_n = 0; idle();
        nx();
        rst_n = 1;
        at_neg();
        chk("rst2_halted", 32'(halted), 0);
        chk("rst2_stall", 32'(stall_cnt), 0);
        chk("rst2_flush", 32'(flush_cnt), 0);
        nx();
        id_halt = 1;
        at_neg();
        nx();
        idle();
        at_neg();
        nx();
        at_neg();
        chk("rd_drain_hold", 32'(pc_hold), 1);
        nx();
        rst_n = 0;
        at_neg();
        nx();
        rst_n = 1;
        at_neg();
        chk("rd_run", 32'(pc_hold), 0);
        chk("rd_halted", 32'(halted), 0);
        nx();
        repeat (6) nx();
        at_neg();
        chk("rd_stays_run", 32'(halted), 0);
        nx();

        load_use(4'd7);
        repeat (65540) nx();
        at_neg();
        chk("stall_saturate", 32'(stall_cnt), CMAX);
        nx();
        idle();
        at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
